id_ex_operand_stage: RTL
========================

// Module: id_ex_operand_stage
// PURPOSE
//  Decode-to-execute pipeline register for the RISC-V core; the stage directly upstream of the 32-bit integer ALU.
//  It registers decoded operands and controls, then forwards from EX/MEM and MEM/WB to drive alu data1/data2/select/rotate.
//  It detects load-use hazards, inserts one bubble per hazard and counts inserted bubbles.
// PARAMETERS
//  XLEN        32  datapath width
//  RA_W        5   register address width
//  CNT_W       16  width of saturating bubble counter
// PORTS
//  CLK              in   1     clock; all state updates on rising edge
//  RESET            in   1     synchronous, active-high reset
//  id_valid         in   1     decode presents an instruction
//  id_ready         out  1     stage accepts it this cycle (transfer = id_valid & id_ready)
//  id_pc/id_imm     in   XLEN  instruction PC / sign-extended immediate
//  id_rs1_data      in   XLEN  register-file read data, port 1 (id_rs2_data likewise)
//  id_rs1_addr      in   RA_W  source 1 address (id_rs2_addr, id_rd_addr likewise)
//  id_uses_rs1/2    in   1     instruction reads rs1 / rs2
//  id_src1_pc       in   1     ALU data1 = PC instead of rs1
//  id_src2_imm      in   1     ALU data2 = imm instead of rs2
//  id_alu_select    in   3     ALU op select, passed through unchanged
//  id_alu_rotate    in   1     ALU rotate/arith modifier, passed through unchanged
//  id_mem_read      in   1     load; id_mem_write, id_reg_write likewise
//  flush            in   1     branch redirect: squash EX contents and incoming instruction
//  stall_in         in   1     downstream freeze: hold all state
//  exm_rd_addr      in   RA_W  EX/MEM dest; exm_reg_write 1, exm_result XLEN
//  wb_rd_addr       in   RA_W  MEM/WB dest; wb_reg_write 1, wb_result XLEN
//  ex_valid         out  1     EX slot holds a live instruction
//  alu_data1/2      out  XLEN  forwarded, muxed ALU operands
//  alu_select       out  3     registered; alu_rotate out 1 registered
//  ex_store_data    out  XLEN  forwarded rs2 (store data)
//  ex_rd_addr       out  RA_W  registered; ex_reg_write/ex_mem_read/ex_mem_write out 1 registered
//  bubble_count     out  CNT_W load-use bubbles inserted since reset
// BEHAVIOUR
//  Reset: ex_valid=0; every registered output, ex_rd_addr and bubble_count = 0; state EMPTY.
//  Reset mid-operation discards the EX instruction with no partial effects.
//  Latency: an accepted instruction appears on outputs the next cycle; forwarding is combinational on registered fields.
//  Hazard (comb.): ex_valid & ex_mem_read & ex_rd_addr!=0 & id_valid &
//   ((id_uses_rs1 & id_rs1_addr==ex_rd_addr) | (id_uses_rs2 & id_rs2_addr==ex_rd_addr)).
//  id_ready = !RESET & !stall_in & !hazard.
//  Per-edge priority: RESET > flush > stall_in > hazard > normal.
//   flush: ex_valid<=0; incoming not accepted even if id_ready=1; counter unchanged.
//   stall_in: all registers and the counter hold.
//   hazard: ex_valid<=0 (bubble); ID instruction held upstream; bubble_count+=1, saturating at all-ones.
//   normal: capture ID fields; ex_valid<=id_valid.
//  FSM: EMPTY(ex_valid=0), LIVE(ex_valid=1), BUBBLE(hazard bubble in EX).
//   EMPTY/BUBBLE->LIVE on transfer. LIVE->BUBBLE on hazard. Any->EMPTY on flush or on !id_valid.
//   At most one consecutive bubble per hazard: in BUBBLE, ex_valid=0, so hazard is false.
//  Forwarding, per source (rs1 shown): EX/MEM match (exm_reg_write & exm_rd_addr==rs1 & rs1!=0) wins;
//   else MEM/WB match; else registered rf data. Register x0 never forwards.
//  alu_data1 = src1_pc ? pc_q : fwd_rs1; alu_data2 = src2_imm ? imm_q : fwd_rs2; ex_store_data = fwd_rs2.
//  When ex_valid=0: outputs hold their last values; ex_reg_write/ex_mem_read/ex_mem_write forced 0.
// STRUCTURE
//  Shared package: XLEN, RA_W, stage-state encoding (EMPTY/LIVE/BUBBLE), forward-select enum (FWD_RF/FWD_EXM/FWD_WB).
//  One sub-module, operand_forward_mux: addresses + three data sources -> forwarded operand; instantiated twice.
// TESTING
//  1 add x3,x1,x2, no matches: rs1=3, rs2=1, select=000 -> next cycle alu_data1=3, alu_data2=1, ex_valid=1.
//  2 rs1=x5 with exm_rd=5 (result 0xA) and wb_rd=5 (0xB) -> alu_data1=0xA; with rd/rs=x0 -> rf data used.
//  3 load to x7 in EX, next instruction reads x7 -> id_ready=0 one cycle; ex_valid=0; bubble_count=1; then accepted.
//  4 flush during hazard cycle -> ex_valid=0 next; bubble_count unchanged; ex_reg_write=0.
//  5 stall_in high 3 cycles with live instruction -> all outputs stable, id_ready=0, counter held.
//  6 RESET mid-stream, then bubble_count forced to 0xFFFF + hazard -> outputs zero / counter stays 0xFFFF.

Source files
------------

// File: rtl/id_ex_operand_stage_pkg.sv
// Shared types for the ID/EX operand stage: widths, stage-state encoding,
// operand forward-select encoding and the registered EX field bundle.
package id_ex_operand_stage_pkg;

  localparam int XLEN      = 32;
  localparam int RA_W      = 5;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_LIVE   = 2'd1,
    ST_BUBBLE = 2'd2
  } stage_state_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EXM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [RA_W-1:0] rs1_addr;
    logic [RA_W-1:0] rs2_addr;
    logic [RA_W-1:0] rd_addr;
    logic            src1_pc;
    logic            src2_imm;
    logic [2:0]      alu_select;
    logic            alu_rotate;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
  } ex_fields_t;

  // A producer can only forward to a non-x0 source it actually writes.
  function automatic logic fwd_hit(input logic            we,
                                   input logic [RA_W-1:0] rd,
                                   input logic [RA_W-1:0] rs);
    return we && (rd == rs) && (rs != '0);
  endfunction

endpackage

// File: rtl/id_ex_operand_stage_operand_forward_mux.sv
// Selects one source operand from EX/MEM, MEM/WB or register-file data;
// the younger EX/MEM result wins when both later stages match.
module operand_forward_mux
  import id_ex_operand_stage_pkg::*;
(
  input  logic [RA_W-1:0] rs_addr,
  input  logic [XLEN-1:0] rf_data,
  input  logic            exm_reg_write,
  input  logic [RA_W-1:0] exm_rd_addr,
  input  logic [XLEN-1:0] exm_result,
  input  logic            wb_reg_write,
  input  logic [RA_W-1:0] wb_rd_addr,
  input  logic [XLEN-1:0] wb_result,
  output logic [XLEN-1:0] fwd_data
);

  fwd_sel_e sel;

  always_comb begin
    // NOTE: default assignment first so no path leaves sel unassigned (no latch).
    sel = FWD_RF;
    if (fwd_hit(exm_reg_write, exm_rd_addr, rs_addr)) begin
      sel = FWD_EXM;
    end else if (fwd_hit(wb_reg_write, wb_rd_addr, rs_addr)) begin
      sel = FWD_WB;
    end
  end

  always_comb begin
    fwd_data = rf_data;
    case (sel)
      FWD_EXM: fwd_data = exm_result;
      FWD_WB:  fwd_data = wb_result;
      default: fwd_data = rf_data;
    endcase
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the integer ALU: registers decoded fields,
// forwards from EX/MEM and MEM/WB, and inserts one bubble per load-use hazard.
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [RA_W-1:0]  id_rs1_addr,
  input  logic [RA_W-1:0]  id_rs2_addr,
  input  logic [RA_W-1:0]  id_rd_addr,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             id_src1_pc,
  input  logic             id_src2_imm,
  input  logic [2:0]       id_alu_select,
  input  logic             id_alu_rotate,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_reg_write,
  input  logic             flush,
  input  logic             stall_in,
  input  logic [RA_W-1:0]  exm_rd_addr,
  input  logic             exm_reg_write,
  input  logic [XLEN-1:0]  exm_result,
  input  logic [RA_W-1:0]  wb_rd_addr,
  input  logic             wb_reg_write,
  input  logic [XLEN-1:0]  wb_result,
  output logic             ex_valid,
  output logic [XLEN-1:0]  alu_data1,
  output logic [XLEN-1:0]  alu_data2,
  output logic [2:0]       alu_select,
  output logic             alu_rotate,
  output logic [XLEN-1:0]  ex_store_data,
  output logic [RA_W-1:0]  ex_rd_addr,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic [CNT_W-1:0] bubble_count
);

  stage_state_e     state_q, state_d;
  ex_fields_t       ex_q, id_fields;
  logic [CNT_W-1:0] bubble_q;
  logic             hazard, transfer;
  logic [XLEN-1:0]  fwd_rs1, fwd_rs2;

  assign id_fields = '{
    pc:         id_pc,
    imm:        id_imm,
    rs1_data:   id_rs1_data,
    rs2_data:   id_rs2_data,
    rs1_addr:   id_rs1_addr,
    rs2_addr:   id_rs2_addr,
    rd_addr:    id_rd_addr,
    src1_pc:    id_src1_pc,
    src2_imm:   id_src2_imm,
    alu_select: id_alu_select,
    alu_rotate: id_alu_rotate,
    mem_read:   id_mem_read,
    mem_write:  id_mem_write,
    reg_write:  id_reg_write
  };

  // A load in EX cannot forward its data yet, so a dependent ID instruction waits.
  assign hazard = ex_valid && ex_q.mem_read && (ex_q.rd_addr != '0) && id_valid &&
                  ((id_uses_rs1 && (id_rs1_addr == ex_q.rd_addr)) ||
                   (id_uses_rs2 && (id_rs2_addr == ex_q.rd_addr)));

  assign id_ready = !RESET && !stall_in && !hazard;
  assign transfer = id_valid && id_ready;

  always_ff @(posedge CLK) begin
    // NOTE: non-blocking in always_ff so every register samples pre-edge values.
    if (RESET) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else if (stall_in) begin
      state_d = state_q;
    end else if (hazard) begin
      state_d = ST_BUBBLE;
    end else if (id_valid) begin
      state_d = ST_LIVE;
    end else begin
      state_d = ST_EMPTY;
    end
  end

  always_comb begin
    ex_valid     = (state_q == ST_LIVE);
    ex_reg_write = ex_valid && ex_q.reg_write;
    ex_mem_read  = ex_valid && ex_q.mem_read;
    ex_mem_write = ex_valid && ex_q.mem_write;
  end

  // Fields only load on a real transfer, so bubbles and flushes leave the
  // previous operands visible while the control strobes read zero.
  always_ff @(posedge CLK) begin
    // NOTE: operand registers are reset too, so outputs read zero after RESET rather than stale data.
    if (RESET) begin
      ex_q <= '0;
    end else if (!flush && transfer) begin
      ex_q <= id_fields;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      bubble_q <= '0;
    end else if (!flush && !stall_in && hazard && (bubble_q != '1)) begin
      bubble_q <= bubble_q + CNT_W'(1);
    end
  end

  operand_forward_mux u_fwd_rs1 (
    .rs_addr       (ex_q.rs1_addr),
    .rf_data       (ex_q.rs1_data),
    .exm_reg_write (exm_reg_write),
    .exm_rd_addr   (exm_rd_addr),
    .exm_result    (exm_result),
    .wb_reg_write  (wb_reg_write),
    .wb_rd_addr    (wb_rd_addr),
    .wb_result     (wb_result),
    .fwd_data      (fwd_rs1)
  );

  operand_forward_mux u_fwd_rs2 (
    .rs_addr       (ex_q.rs2_addr),
    .rf_data       (ex_q.rs2_data),
    .exm_reg_write (exm_reg_write),
    .exm_rd_addr   (exm_rd_addr),
    .exm_result    (exm_result),
    .wb_reg_write  (wb_reg_write),
    .wb_rd_addr    (wb_rd_addr),
    .wb_result     (wb_result),
    .fwd_data      (fwd_rs2)
  );

  assign alu_data1     = ex_q.src1_pc  ? ex_q.pc  : fwd_rs1;
  assign alu_data2     = ex_q.src2_imm ? ex_q.imm : fwd_rs2;
  assign ex_store_data = fwd_rs2;
  assign alu_select    = ex_q.alu_select;
  assign alu_rotate    = ex_q.alu_rotate;
  assign ex_rd_addr    = ex_q.rd_addr;
  assign bubble_count  = bubble_q;

endmodule
